// File: rtl/thiele_logic_bridge_pkg.sv
// rtl/thiele_logic_bridge_pkg.sv - shared state encodings and defaults for the logic bridge
package thiele_logic_bridge_pkg;

  // Bridge FSM states (3-bit encoding).
  typedef enum logic [2:0] {
    LB_IDLE  = 3'd0,
    LB_ISSUE = 3'd1,
    LB_WAIT  = 3'd2,
    LB_ACK   = 3'd3,
    LB_DRAIN = 3'd4
  } lb_state_e;

  // Default payload returned to the CPU when the engine never answers.
  localparam logic [31:0] LB_TIMEOUT_DATA = 32'hDEAD_0000;

endpackage

// File: rtl/thiele_logic_bridge_if.sv
// rtl/thiele_logic_bridge_if.sv - engine-side request/response handshake bundle
// Ports (via modports):
//   master (bridge): drives eng_req_valid/addr/tag and eng_rsp_ready;
//                    samples eng_req_ready and eng_rsp_valid/tag/data
//   slave  (engine): the mirror image
interface thiele_logic_bridge_if #(
  parameter int TAG_W = 4
) ();

  logic             eng_req_valid;
  logic             eng_req_ready;
  logic [31:0]      eng_req_addr;
  logic [TAG_W-1:0] eng_req_tag;
  logic             eng_rsp_valid;
  logic             eng_rsp_ready;
  logic [TAG_W-1:0] eng_rsp_tag;
  logic [31:0]      eng_rsp_data;

  modport master (
    output eng_req_valid, eng_req_addr, eng_req_tag, eng_rsp_ready,
    input  eng_req_ready, eng_rsp_valid, eng_rsp_tag, eng_rsp_data
  );

  modport slave (
    input  eng_req_valid, eng_req_addr, eng_req_tag, eng_rsp_ready,
    output eng_req_ready, eng_rsp_valid, eng_rsp_tag, eng_rsp_data
  );

endinterface

// File: rtl/thiele_logic_bridge_sat_counter.sv
// rtl/thiele_logic_bridge_sat_counter.sv - 32-bit statistics counter, saturating or wrapping
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (clears count)
//   inc         add one this cycle
//   sat_mode    1: hold at all-ones, 0: wrap to zero
//   count       current value
module lb_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        sat_mode,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(sat_mode && (count_q == 32'hFFFF_FFFF))) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/thiele_logic_bridge.sv
// rtl/thiele_logic_bridge.sv - CPU logic-port to tagged engine transaction bridge with timeout
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   logic_req, logic_addr  CPU level-held request and address
//   logic_ack, logic_data  one-cycle response pulse and held response data
//   eng                    engine request/response handshake (master side)
//   txn_count              completed transactions, wraps
//   timeout_count          timed-out transactions, saturates
//   stale_count            dropped engine responses, saturates
//   timeout_flag           sticky timeout indicator
module thiele_logic_bridge
  import thiele_logic_bridge_pkg::*;
#(
  parameter int          TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = LB_TIMEOUT_DATA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   logic_req,
  input  logic [31:0]            logic_addr,
  output logic                   logic_ack,
  output logic [31:0]            logic_data,
  thiele_logic_bridge_if.master  eng,
  output logic [31:0]            txn_count,
  output logic [31:0]            timeout_count,
  output logic [31:0]            stale_count,
  output logic                   timeout_flag
);

  lb_state_e        state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      data_q, data_d;
  logic             ack_q, ack_d;
  logic             req_valid_q, req_valid_d;
  logic             rsp_ready_q, rsp_ready_d;
  logic             flag_q, flag_d;
  logic             txn_inc, timeout_inc, stale_inc;
  logic             rsp_fire;

  assign rsp_fire = eng.eng_rsp_valid && rsp_ready_q;

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    data_d      = data_q;
    flag_d      = flag_q;
    txn_inc     = 1'b0;
    timeout_inc = 1'b0;
    stale_inc   = 1'b0;

    case (state_q)
      LB_IDLE: begin
        if (logic_req) begin
          addr_d  = logic_addr;
          state_d = LB_ISSUE;
        end
      end
      LB_ISSUE: begin
        if (eng.eng_req_ready) begin
          timer_d = 32'd0;
          state_d = LB_WAIT;
        end
      end
      LB_WAIT: begin
        // A matching response beats a timeout landing in the same cycle.
        if (rsp_fire && (eng.eng_rsp_tag == tag_q)) begin
          data_d  = eng.eng_rsp_data;
          state_d = LB_ACK;
        end else begin
          if (rsp_fire) begin
            stale_inc = 1'b1;
          end
          if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
            data_d      = TIMEOUT_DATA;
            timeout_inc = 1'b1;
            flag_d      = 1'b1;
            state_d     = LB_ACK;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
      end
      LB_ACK: begin
        txn_inc = 1'b1;
        tag_d   = tag_q + TAG_W'(1);
        state_d = LB_DRAIN;
      end
      LB_DRAIN: begin
        // Request is still high right after the ack; wait for it to fall.
        if (!logic_req) begin
          state_d = LB_IDLE;
        end
      end
      default: state_d = LB_IDLE;
    endcase

    // Anything accepted while idle or draining belongs to no open transaction.
    if (rsp_fire && (state_q != LB_WAIT)) begin
      stale_inc = 1'b1;
    end

    // Outputs are registered from the next state so they line up with state_q.
    ack_d       = (state_d == LB_ACK);
    req_valid_d = (state_d == LB_ISSUE);
    rsp_ready_d = (state_d == LB_IDLE) || (state_d == LB_WAIT) || (state_d == LB_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LB_IDLE;
      tag_q       <= '0;
      addr_q      <= 32'd0;
      timer_q     <= 32'd0;
      data_q      <= 32'd0;
      ack_q       <= 1'b0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b1;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      addr_q      <= addr_d;
      timer_q     <= timer_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      req_valid_q <= req_valid_d;
      rsp_ready_q <= rsp_ready_d;
      flag_q      <= flag_d;
    end
  end

  assign logic_ack         = ack_q;
  assign logic_data        = data_q;
  assign timeout_flag      = flag_q;
  assign eng.eng_req_valid = req_valid_q;
  assign eng.eng_req_addr  = addr_q;
  assign eng.eng_req_tag   = tag_q;
  assign eng.eng_rsp_ready = rsp_ready_q;

  lb_sat_counter u_txn_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (txn_inc),
    .sat_mode (1'b0),
    .count    (txn_count)
  );

  lb_sat_counter u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (timeout_inc),
    .sat_mode (1'b1),
    .count    (timeout_count)
  );

  lb_sat_counter u_stale_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (stale_inc),
    .sat_mode (1'b1),
    .count    (stale_count)
  );

endmodule

// File: tb/tb_thiele_logic_bridge.sv
// tb/tb_thiele_logic_bridge.sv - directed self-checking bench for thiele_logic_bridge
module tb_thiele_logic_bridge;

  logic        clk;
  logic        rst_n;
  logic        logic_req;
  logic [31:0] logic_addr;
  logic        logic_ack;
  logic [31:0] logic_data;
  logic [31:0] txn_count;
  logic [31:0] timeout_count;
  logic [31:0] stale_count;
  logic        timeout_flag;

  int total;
  int bad;
  int hs_count;

  thiele_logic_bridge_if #(.TAG_W(4)) eng_if ();

  thiele_logic_bridge #(
    .TAG_W          (4),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_DATA   (32'hDEAD_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .logic_req     (logic_req),
    .logic_addr    (logic_addr),
    .logic_ack     (logic_ack),
    .logic_data    (logic_data),
    .eng           (eng_if),
    .txn_count     (txn_count),
    .timeout_count (timeout_count),
    .stale_count   (stale_count),
    .timeout_flag  (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n                = 1'b0;
    logic_req            = 1'b0;
    eng_if.eng_rsp_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ack"},       32'(logic_ack), 32'd0);
    chk({pfx, "_data"},      logic_data, 32'd0);
    chk({pfx, "_req_valid"}, 32'(eng_if.eng_req_valid), 32'd0);
    chk({pfx, "_req_addr"},  eng_if.eng_req_addr, 32'd0);
    chk({pfx, "_req_tag"},   32'(eng_if.eng_req_tag), 32'd0);
    chk({pfx, "_rsp_ready"}, 32'(eng_if.eng_rsp_ready), 32'd1);
    chk({pfx, "_txn"},       txn_count, 32'd0);
    chk({pfx, "_tmo_cnt"},   timeout_count, 32'd0);
    chk({pfx, "_stale"},     stale_count, 32'd0);
    chk({pfx, "_flag"},      32'(timeout_flag), 32'd0);
  endtask

  initial begin
    total                = 0;
    bad                  = 0;
    hs_count             = 0;
    rst_n                = 1'b0;
    logic_req            = 1'b0;
    logic_addr           = 32'd0;
    eng_if.eng_req_ready = 1'b0;
    eng_if.eng_rsp_valid = 1'b0;
    eng_if.eng_rsp_tag   = 4'd0;
    eng_if.eng_rsp_data  = 32'd0;

    // Reset state
    tick();
    tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Basic transaction, then CPU holds req for 3 cycles after the ack
    logic_req            = 1'b1;
    logic_addr           = 32'h0000_0040;
    eng_if.eng_req_ready = 1'b1;
    tick();
    chk("basic_valid", 32'(eng_if.eng_req_valid), 32'd1);
    chk("basic_addr",  eng_if.eng_req_addr, 32'h0000_0040);
    chk("basic_tag",   32'(eng_if.eng_req_tag), 32'd0);
    tick();
    chk("basic_wait_valid", 32'(eng_if.eng_req_valid), 32'd0);
    chk("basic_wait_ready", 32'(eng_if.eng_rsp_ready), 32'd1);
    tick();
    eng_if.eng_rsp_valid = 1'b1;
    eng_if.eng_rsp_tag   = 4'd0;
    eng_if.eng_rsp_data  = 32'hABCD_1234;
    tick();
    chk("basic_ack",  32'(logic_ack), 32'd1);
    chk("basic_data", logic_data, 32'hABCD_1234);
    eng_if.eng_rsp_valid = 1'b0;
    tick();
    chk("basic_ack_pulse", 32'(logic_ack), 32'd0);
    chk("basic_txn",       txn_count, 32'd1);
    chk("basic_next_tag",  32'(eng_if.eng_req_tag), 32'd1);
    chk("basic_data_held", logic_data, 32'hABCD_1234);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold_no_valid", 32'(eng_if.eng_req_valid), 32'd0);
      chk("hold_no_ack",   32'(logic_ack), 32'd0);
    end
    logic_req = 1'b0;
    tick();
    chk("hold_low_no_valid", 32'(eng_if.eng_req_valid), 32'd0);

    // Back-pressure: engine not ready for 5 cycles
    logic_req            = 1'b1;
    logic_addr           = 32'h0000_0080;
    eng_if.eng_req_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(eng_if.eng_req_valid), 32'd1);
      chk("bp_addr",  eng_if.eng_req_addr, 32'h0000_0080);
      chk("bp_tag",   32'(eng_if.eng_req_tag), 32'd1);
      tick();
    end
    eng_if.eng_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (eng_if.eng_req_valid && eng_if.eng_req_ready) hs_count++;
      tick();
    end
    chk("bp_handshakes", 32'(hs_count), 32'd1);
    eng_if.eng_rsp_valid = 1'b1;
    eng_if.eng_rsp_tag   = 4'd1;
    eng_if.eng_rsp_data  = 32'h0000_1111;
    tick();
    chk("bp_ack",  32'(logic_ack), 32'd1);
    chk("bp_data", logic_data, 32'h0000_1111);
    eng_if.eng_rsp_valid = 1'b0;
    logic_req            = 1'b0;
    tick();
    tick();

    // Timeout with TIMEOUT_CYCLES=8, then a late response
    do_reset();
    logic_req = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("tmo_no_early_ack", 32'(logic_ack), 32'd0);
    end
    tick();
    chk("tmo_ack",     32'(logic_ack), 32'd1);
    chk("tmo_data",    logic_data, 32'hDEAD_0000);
    chk("tmo_flag",    32'(timeout_flag), 32'd1);
    chk("tmo_count",   timeout_count, 32'd1);
    logic_req = 1'b0;
    tick();
    eng_if.eng_rsp_valid = 1'b1;
    eng_if.eng_rsp_tag   = 4'd0;
    eng_if.eng_rsp_data  = 32'h7777_7777;
    tick();
    eng_if.eng_rsp_valid = 1'b0;
    chk("late_stale",  stale_count, 32'd1);
    chk("late_no_ack", 32'(logic_ack), 32'd0);
    tick();
    chk("late_no_ack2", 32'(logic_ack), 32'd0);
    chk("late_txn",     txn_count, 32'd1);
    chk("late_flag",    32'(timeout_flag), 32'd1);

    // Tag mismatch: tag 3 dropped, tag 0 accepted
    do_reset();
    chk("mm_flag_cleared", 32'(timeout_flag), 32'd0);
    logic_req = 1'b1;
    tick();
    tick();
    eng_if.eng_rsp_valid = 1'b1;
    eng_if.eng_rsp_tag   = 4'd3;
    eng_if.eng_rsp_data  = 32'h0000_0099;
    tick();
    chk("mm_drop_no_ack", 32'(logic_ack), 32'd0);
    chk("mm_drop_stale",  stale_count, 32'd1);
    eng_if.eng_rsp_tag  = 4'd0;
    eng_if.eng_rsp_data = 32'h0000_0055;
    tick();
    eng_if.eng_rsp_valid = 1'b0;
    chk("mm_ack",   32'(logic_ack), 32'd1);
    chk("mm_data",  logic_data, 32'h0000_0055);
    chk("mm_stale", stale_count, 32'd1);
    logic_req = 1'b0;
    tick();
    tick();

    // Tag wrap over 17 transactions
    do_reset();
    for (int i = 0; i < 17; i++) begin
      logic_req  = 1'b1;
      logic_addr = 32'h1000 + 32'(i);
      tick();
      chk("wrap_tag", 32'(eng_if.eng_req_tag), 32'(i % 16));
      tick();
      eng_if.eng_rsp_valid = 1'b1;
      eng_if.eng_rsp_tag   = 4'(i % 16);
      eng_if.eng_rsp_data  = 32'h5000 + 32'(i);
      tick();
      chk("wrap_ack",  32'(logic_ack), 32'd1);
      chk("wrap_data", logic_data, 32'h5000 + 32'(i));
      eng_if.eng_rsp_valid = 1'b0;
      logic_req            = 1'b0;
      tick();
      tick();
    end
    chk("wrap_txn",      txn_count, 32'd17);
    chk("wrap_next_tag", 32'(eng_if.eng_req_tag), 32'd1);

    // Reset asserted while in WAIT
    logic_req  = 1'b1;
    logic_addr = 32'h0000_0ABC;
    tick();
    tick();
    chk("rw_in_wait", 32'(eng_if.eng_rsp_ready), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("rw");
    rst_n     = 1'b1;
    logic_req = 1'b0;
    tick();
    chk("rw_no_ack",   32'(logic_ack), 32'd0);
    chk("rw_no_valid", 32'(eng_if.eng_req_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
